// File: rtl/threshold_fifo.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds and a
// sticky overflow flag; status outputs feed the link control FSM.
module threshold_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error_out,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         alto_q;
    logic [CW-1:0]         bajo_q;

    logic rd_ok;
    logic wr_ok;
    logic overflow;

    // Handshake: a read is accepted when rd_en=1 and the FIFO holds a word; its data
    // appears on data_out with valid_out=1 one clock later. A write is accepted when
    // wr_en=1 and a slot is free, or a same-cycle accepted read frees one. A write
    // into a full FIFO without a read is dropped and raises error_out.
    always_comb begin
        rd_ok    = rd_en && !fifo_empty;
        wr_ok    = wr_en && (!fifo_full || rd_ok);
        overflow = wr_en && fifo_full && !rd_en;
    end

    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == DEPTH_C);
        almost_full  = (count_q >= alto_q);
        almost_empty = (count_q <= bajo_q);
        count        = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
            alto_q    <= DEPTH_C - CW'(1);
            bajo_q    <= CW'(1);
        end else begin
            if (init) begin
                alto_q <= umbral_alto;
                bajo_q <= umbral_bajo;
            end

            if (init) begin
                error_out <= 1'b0;
            end else if (overflow) begin
                error_out <= 1'b1;
            end

            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end

            valid_out <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end

            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // When full with a simultaneous read, wr_ptr == rd_ptr: the read above samples
    // the old word before this write replaces it.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_threshold_fifo.sv
// Directed bench for threshold_fifo: reads push expected words into a queue that a
// negedge monitor pops whenever valid_out is high.
module tb_threshold_fifo;

    localparam int DW = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [AW:0]   umbral_alto;
    logic [AW:0]   umbral_bajo;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic          error_out;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_q[$];

    threshold_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error_out    (error_out),
        .count        (count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented word must be the oldest outstanding expected read
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: unexpected word 0x%0h with no read pending at %0t",
                         data_out, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", data_out, e, $time);
                end
            end
        end
    end

    // One clock with the given write/read request; ends at the following negedge
    task automatic op(input logic w, input logic [DW-1:0] d, input logic r);
        bit rd_acc;
        bit wr_acc;
        rd_acc = r && (model_q.size() > 0);
        wr_acc = w && ((model_q.size() < 8) || rd_acc);
        if (rd_acc) exp_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(d);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("count", 32'(count), 32'(model_q.size()));
    endtask

    task automatic init_pulse(input logic [AW:0] a, input logic [AW:0] b);
        init        = 1'b1;
        umbral_alto = a;
        umbral_bajo = b;
        @(posedge clk);
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic drain();
        while (model_q.size() > 0) op(1'b0, '0, 1'b1);
        op(1'b0, '0, 1'b0);
    endtask

    logic [19:0] wr_pat;
    logic [19:0] rd_pat;

    initial begin
        reset = 1'b1; init = 1'b0; umbral_alto = '0; umbral_bajo = '0;
        wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // 1. Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_error", 32'(error_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_data_out", 32'(data_out), 0);

        // 2. Thresholds 6/2, fill 1..8 then read back in order
        init_pulse(4'd6, 4'd2);
        for (int k = 1; k <= 8; k++) begin
            op(1'b1, DW'(k), 1'b0);
            chk("t2_almost_empty", 32'(almost_empty), (k <= 2) ? 1 : 0);
            chk("t2_almost_full", 32'(almost_full), (k >= 6) ? 1 : 0);
            chk("t2_full", 32'(fifo_full), (k == 8) ? 1 : 0);
        end
        for (int k = 1; k <= 8; k++) begin
            op(1'b0, '0, 1'b1);
            chk("t2_valid", 32'(valid_out), 1);
            chk("t2_data", 32'(data_out), 32'(k));
        end
        chk("t2_empty", 32'(fifo_empty), 1);
        op(1'b0, '0, 1'b0);
        chk("t2_valid_idle", 32'(valid_out), 0);

        // 3. Overflow
        for (int k = 0; k < 8; k++) op(1'b1, DW'(8'h10 + k), 1'b0);
        op(1'b1, 6'h3F, 1'b0);
        chk("t3_error", 32'(error_out), 1);
        chk("t3_count", 32'(count), 8);
        op(1'b0, '0, 1'b0);
        chk("t3_error_sticky", 32'(error_out), 1);
        drain();
        chk("t3_error_after_reads", 32'(error_out), 1);
        chk("t3_last_word", 32'(data_out), 32'h17);
        init_pulse(4'd6, 4'd2);
        chk("t3_error_cleared", 32'(error_out), 0);

        // 4. Underflow
        for (int k = 0; k < 3; k++) begin
            op(1'b0, '0, 1'b1);
            chk("t4_valid", 32'(valid_out), 0);
            chk("t4_error", 32'(error_out), 0);
            chk("t4_data_held", 32'(data_out), 32'h17);
        end

        // 5. Simultaneous read/write when full, then when empty
        for (int k = 0; k < 8; k++) op(1'b1, DW'(8'h20 + k), 1'b0);
        op(1'b1, 6'h2A, 1'b1);
        chk("t5_full_count", 32'(count), 8);
        chk("t5_full_error", 32'(error_out), 0);
        chk("t5_full_data", 32'(data_out), 32'h20);
        for (int k = 0; k < 8; k++) op(1'b0, '0, 1'b1);
        chk("t5_last_data", 32'(data_out), 32'h2A);
        chk("t5_empty", 32'(fifo_empty), 1);
        op(1'b1, 6'h15, 1'b1);
        chk("t5_empty_count", 32'(count), 1);
        chk("t5_empty_valid", 32'(valid_out), 0);
        op(1'b0, '0, 1'b1);
        chk("t5_bypass_data", 32'(data_out), 32'h15);

        // 6. Interleaved traffic across pointer wrap, then reset with 5 words stored
        wr_pat = 20'b1111_0111_1101_1111_1011;
        rd_pat = 20'b0110_1101_1010_0110_1100;
        for (int i = 0; i < 20; i++) op(wr_pat[i], DW'(8'h30 + i), rd_pat[i]);
        drain();
        for (int k = 0; k < 5; k++) op(1'b1, DW'(8'h08 + k), 1'b0);
        chk("t6_count_before_reset", 32'(count), 5);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_empty", 32'(fifo_empty), 1);
        chk("t6_rst_valid", 32'(valid_out), 0);
        for (int k = 0; k < 2; k++) begin
            op(1'b0, '0, 1'b1);
            chk("t6_rd_ignored_valid", 32'(valid_out), 0);
        end
        for (int k = 1; k <= 7; k++) begin
            op(1'b1, DW'(8'h01 + k), 1'b0);
            chk("t6_thr_almost_empty", 32'(almost_empty), (k <= 1) ? 1 : 0);
            chk("t6_thr_almost_full", 32'(almost_full), (k >= 7) ? 1 : 0);
        end
        drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/threshold_fifo.md
Name: threshold_fifo

Overview:
- Synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Feeds the status inputs of the link control FSM (empty, full, threshold pauses, overflow error) and sits on each VC/data path between demux and consumer.
- Thresholds load during the control FSM's INIT phase. The block is the status-producing end of the FSM/FIFO control interface.

Parameters:
- DATA_WIDTH, 6, width of each stored word
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- init  in  1  while high, threshold inputs are latched each cycle
- umbral_alto  in  ADDR_WIDTH+1  almost-full threshold (occupancy)
- umbral_bajo  in  ADDR_WIDTH+1  almost-empty threshold (occupancy)
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data, registered
- valid_out  out  1  data_out holds a word popped in the previous cycle
- fifo_empty  out  1  occupancy == 0
- fifo_full  out  1  occupancy == DEPTH
- almost_full  out  1  occupancy >= latched umbral_alto
- almost_empty  out  1  occupancy <= latched umbral_bajo
- error_out  out  1  sticky overflow flag
- count  out  ADDR_WIDTH+1  current occupancy

Behaviour:
- Reset (sampled at clk edge while reset=1):
  - Pointers and count go to 0; data_out=0; valid_out=0; error_out=0.
  - Latched thresholds: alto=DEPTH-1, bajo=1.
  - Memory contents are don't-care.
  - Reset overrides init, wr_en and rd_en in the same cycle.
- Init:
  - While init=1 (and reset=0), umbral_alto and umbral_bajo are registered every cycle.
  - error_out clears.
  - FIFO contents and pointers are untouched.
  - wr_en/rd_en are still honoured during init.
- Write:
  - If wr_en=1 and the FIFO is not full, data_in is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - Write when full with no read: the word is dropped, pointers are unchanged, and error_out sets to 1 on the next edge. It stays 1 until reset or init.
- Read:
  - If rd_en=1 and the FIFO is not empty, mem[rd_ptr] is registered onto data_out and rd_ptr increments, wrapping.
  - valid_out=1 in the following cycle. Latency is 1 clock from the rd_en edge.
  - Read when empty: ignored. valid_out=0, data_out holds its last value, no error.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both happen, count is unchanged.
  - Full: both happen (the read frees the slot), count stays DEPTH, no error.
  - Empty: the write is accepted and the read is ignored (no bypass). count becomes 1, valid_out=0.
- Count: +1 on an accepted write only, -1 on an accepted read only; otherwise unchanged. Never exceeds DEPTH and never goes below 0.
- Status outputs:
  - fifo_empty, fifo_full, almost_full and almost_empty are combinational from the registered count and latched thresholds. They reflect occupancy after the last edge.
  - With umbral_alto > DEPTH, almost_full never asserts.
  - With umbral_bajo >= DEPTH, almost_empty is always 1. This is legal and not an error.
- Write data is registered into memory only. data_out never changes without an accepted read, reset, or nothing.

Test Plan:
1. Reset → outputs: reset=1 for 2 cycles, then release → count=0, fifo_empty=1, almost_empty=1 (bajo=1), almost_full=0, fifo_full=0, error_out=0, valid_out=0.
2. Thresholds and ordering:
   - Stimulus: init=1 one cycle with alto=6, bajo=2; then write 0x01..0x08 on consecutive cycles.
   - Response: almost_empty drops after the 3rd write; almost_full rises after the 6th; fifo_full=1 after the 8th.
   - Then 8 reads: data_out=0x01..0x08 in order, each one cycle after rd_en, valid_out high for 8 cycles; fifo_empty=1 at the end.
3. Overflow:
   - Stimulus: fill to 8, write 0x3F.
   - Response: error_out=1 next cycle, count=8; the next reads return the original 8 words and 0x3F is absent.
   - error_out stays 1 until an init pulse clears it.
4. Underflow: empty FIFO, rd_en=1 for 3 cycles → valid_out=0, count=0, error_out=0, data_out unchanged.
5. Simultaneous read/write at boundaries:
   - Full + wr/rd with data 0x2A: count stays 8, error_out=0, and 0x2A is read last.
   - Empty + wr/rd with data 0x15: count=1, valid_out=0; the next read returns 0x15.
6. Wrap and mid-operation reset:
   - Stimulus: 20 cycles of interleaved writes/reads forcing pointer wrap, checked against a scoreboard; then assert reset with 5 words stored.
   - Response: next cycle count=0, fifo_empty=1, thresholds back to 7/1; subsequent reads are ignored.
